wb_lsu: RTL and testbench
=========================

Name: wb_lsu

Overview:
- Load/store unit for the RV32 core.
- Converts one core load/store request into a single pipelined Wishbone classic-pipelined transaction toward the on-chip word-addressed memory.
- Handles byte/half/word lane selection, store-data replication, load alignment and sign/zero extension, misalignment detection, bus error and bus timeout.
- Sits between the execute stage and the data memory.

Parameters:
- AW, 13, Wishbone word-address width. The byte address is AW+2 bits.
- TIMEOUT, 255, cycles without ack before the transaction is aborted as an error. Must be at least 2.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_stb  in  1  core request valid. Sampled only when o_busy=0.
- i_we  in  1  1=store, 0=load
- i_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- i_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- i_addr  in  32  byte address. Only bits [AW+1:0] are used.
- i_wdata  in  32  store data, right-justified
- o_busy  out  1  request in progress; i_stb is ignored while high
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done: misaligned, illegal size, bus error or timeout
- o_rdata  out  32  load result, valid with o_done when !o_err
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- o_wb_we  out  1  Wishbone write enable
- o_wb_addr  out  AW  Wishbone word address
- o_wb_data  out  32  Wishbone write data
- o_wb_sel  out  4  Wishbone byte lane select
- i_wb_ack  in  1  Wishbone acknowledge
- i_wb_stall  in  1  Wishbone stall
- i_wb_err  in  1  Wishbone error
- i_wb_data  in  32  Wishbone read data

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we = 0.
  - o_rdata, o_wb_addr, o_wb_data, o_wb_sel = 0.
  - Timeout counter = 0.
  - Reset mid-transaction drops cyc/stb at once; any later ack is ignored.
- State IDLE, i_stb=1:
  - Compute off=i_addr[1:0].
  - Misaligned when size=01 and off[0]=1, or size=10 and off!=0.
  - If misaligned or size=11: next cycle o_done=1, o_err=1, no bus cycle, stay IDLE.
  - Otherwise register the following and go to REQ with o_busy=1, cyc=1, stb=1:
    - addr = i_addr[AW+1:2]
    - we = i_we
    - sel: byte = 0001<<off; half = 0011<<off; word = 1111
    - wdata: byte = {4{i_wdata[7:0]}}; half = {2{i_wdata[15:0]}}; word = i_wdata
    - off, size and i_unsigned, kept for the load result
- State REQ:
  - Hold stb and all o_wb_* stable while i_wb_stall=1.
  - On stall=0, the next cycle stb=0 and state goes to WAIT.
  - If ack or err arrives in the same cycle stall=0, go directly to completion.
- State WAIT:
  - cyc=1, stb=0.
  - On ack: next cycle cyc=0, o_done=1, o_err=0, return to IDLE.
  - On err: next cycle cyc=0, o_done=1, o_err=1.
  - err takes priority over a simultaneous ack.
- Load result:
  - Shift i_wb_data right by 8*off.
  - Byte: extend bit 7. Half: extend bit 15. Extension is zero when i_unsigned=1, sign otherwise.
  - Word: pass through unchanged.
  - For stores, o_rdata is unchanged.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no ack: next cycle cyc=stb=0, o_done=1, o_err=1.
- Busy and done timing:
  - o_busy=1 from the cycle after acceptance through the cycle before o_done.
  - o_busy=0 in the o_done cycle, so a new i_stb may be accepted that cycle.
- Latency with a zero-stall, next-cycle-ack slave:
  - i_stb accepted at cycle N.
  - stb high at N+1.
  - ack at N+2.
  - o_done at N+3.
- One outstanding transaction only. No retry.

Test Plan:
- Aligned word store, then load:
  - Store addr=0x0000_0010, wdata=0xDEADBEEF -> wb_addr=4, sel=1111, we=1, o_done 3 cycles after accept, o_err=0.
  - Load of the same address -> o_rdata=0xDEADBEEF.
- Byte loads at addr=0x13 with memory word 0x80FF7F01:
  - Signed -> 0xFFFFFF80.
  - Unsigned -> 0x00000080.
  - sel=1000 in both cases.
- Half store at addr=0x6, wdata=0x0000ABCD -> sel=1100, wb_data=0xABCDABCD.
  - Signed half load back -> 0xFFFFABCD.
- Misaligned and illegal requests produce no bus cycle:
  - Word at 0x2 -> cyc never asserted, o_done=1 and o_err=1 the next cycle.
  - Half at 0x1 -> same response.
  - size=11 -> same response.
- Stall for 3 cycles -> stb, addr, sel and data held stable all 3 cycles; completion shifts by 3 cycles.
  - i_wb_err in WAIT -> o_done with o_err=1, cyc dropped.
- No ack with TIMEOUT=4 -> o_err pulse at counter 4, cyc=0.
  - Assert reset while in WAIT -> cyc/stb drop immediately and no o_done.
  - A late ack after reset is ignored.

Source files
------------

// File: rtl/wb_lsu.sv
// wb_lsu: RV32 load/store unit issuing one Wishbone pipelined transaction per core request
module wb_lsu #(
    parameter int AW      = 13,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stb,
    input  logic          i_we,
    input  logic [1:0]    i_size,
    input  logic          i_unsigned,
    input  logic [31:0]   i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [31:0]   o_rdata,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [31:0]   i_wb_data
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [3:0]    sel_q, sel_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;

    logic [1:0]    off;
    logic          bad;
    logic          tmo;
    logic [31:0]   shifted;
    logic [31:0]   ld_val;
    logic          unused_addr_bits;

    // Upper byte-address bits lie outside the memory window and are ignored.
    assign unused_addr_bits = ^i_addr[31:AW+2];

    assign off = i_addr[1:0];
    assign bad = (i_size == 2'b11) || (i_size == 2'b01 && off[0]) || (i_size == 2'b10 && off != 2'b00);
    assign tmo = cnt_q == CW'(TIMEOUT);

    // Words have offset zero, so the shifted value is the raw bus word for them.
    assign shifted = i_wb_data >> {off_q, 3'b000};
    assign ld_val  = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
                     size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;

    assign o_busy    = state_q != IDLE;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_rdata   = rdata_q;
    assign o_wb_cyc  = state_q != IDLE;
    assign o_wb_stb  = state_q == REQ;
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = wdat_q;
    assign o_wb_sel  = sel_q;

    // Next state: accept/reject requests in IDLE, track stall, ack, error and timeout on the bus.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        case (state_q)
            IDLE: begin
                if (i_stb && bad) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else if (i_stb) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    we_d    = i_we;
                    addr_d  = i_addr[AW+1:2];
                    sel_d   = i_size == 2'b00 ? 4'b0001 << off : i_size == 2'b01 ? 4'b0011 << off : 4'b1111;
                    wdat_d  = i_size == 2'b00 ? {4{i_wdata[7:0]}} : i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
                    off_d   = off;
                    size_d  = i_size;
                    uns_d   = i_unsigned;
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == REQ && !i_wb_stall) state_d = WAIT;
                if (i_wb_ack || i_wb_err || tmo) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = i_wb_err || !i_wb_ack;
                    if (!we_q && i_wb_ack && !i_wb_err) rdata_d = ld_val;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any bus cycle immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
        end
    end
endmodule

// File: tb/tb_wb_lsu.sv
// tb_wb_lsu: random and directed load/store traffic against a transaction-level model of wb_lsu
module tb_wb_lsu;
    localparam int AW = 13;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_stb = 1'b0, i_we = 1'b0, i_unsigned = 1'b0;
    logic [1:0]    i_size = 2'b00;
    logic [31:0]   i_addr = '0, i_wdata = '0;
    logic          o_busy, o_done, o_err;
    logic [31:0]   o_rdata;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_ack = 1'b0, i_wb_stall = 1'b0, i_wb_err = 1'b0;
    logic [31:0]   i_wb_data = '0;

    wb_lsu #(.AW(AW), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_reset(rst), .i_stb(i_stb), .i_we(i_we), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
        .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc_n = 0;
    logic [31:0] mem [0:(1<<AW)-1];

    int acc_at = -10, done_at = -10;
    bit bus_x = 0, err_x = 0, we_x = 0, chk_en = 0, rd_known = 1, busy_e;
    logic [31:0] rd_x = '0, rd_model = '0;

    int got_lat;
    bit got_err;
    logic [31:0] got_rd, cap_data;
    logic [3:0] cap_sel;
    logic [AW-1:0] cap_addr;
    bit cap_we;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_n);
        end
    endtask

    // Cycle counter used to schedule expected events.
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Compare process: every cycle, handshake outputs against the scheduled transaction.
    always @(negedge clk) begin
        if (chk_en) begin
            busy_e = bus_x && cyc_n > acc_at && cyc_n < done_at;
            check("busy", o_busy, busy_e);
            check("wb_cyc", o_wb_cyc, busy_e);
            check("done", o_done, cyc_n == done_at);
            if (cyc_n == done_at) begin
                check("err", o_err, err_x);
                if (!err_x && !we_x) begin
                    rd_model = rd_x;
                    rd_known = 1;
                end else if (err_x && !we_x) rd_known = 0;
                if (rd_known) check("rdata", o_rdata, rd_model);
            end
        end
    end

    // One request plus the slave's response: s stall cycles, ack/err d cycles after acceptance.
    task automatic xact(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wd, input int s, input int d, input bit berr, input bit noack);
        logic [1:0] off;
        bit bad, tout;
        int lat, tot, k;
        logic [3:0] sel_e;
        logic [31:0] dat_e, sh, res;
        logic [AW-1:0] wa;
        off   = addr[1:0];
        bad   = sz == 2'd3 || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
        wa    = addr[AW+1:2];
        sel_e = sz == 2'd0 ? 4'b0001 << off : sz == 2'd1 ? 4'b0011 << off : 4'b1111;
        dat_e = sz == 2'd0 ? {4{wd[7:0]}} : sz == 2'd1 ? {2{wd[15:0]}} : wd;
        sh    = mem[wa] >> (8 * off);
        res   = sh;
        if (sz == 2'd0) begin
            res = sh & 32'hFF;
            if (!uns && res >= 128) res = res - 256;
        end else if (sz == 2'd1) begin
            res = sh & 32'hFFFF;
            if (!uns && res >= 32768) res = res - 65536;
        end
        tot  = noack ? T + 1 : s + d;
        tout = tot > T;
        lat  = bad ? 1 : 2 + (tout ? T : tot);
        i_stb = 1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = addr; i_wdata = wd;
        @(posedge clk); #1;
        k = cyc_n - 1;
        acc_at = k; done_at = k + lat; bus_x = !bad; we_x = we; rd_x = res;
        err_x = bad || tout || berr;
        i_stb = 0;
        got_lat = (lat == 1 && o_done) ? 1 : -1;
        cap_sel = '0; cap_addr = '0; cap_data = '0; cap_we = 0;
        for (int j = 1; j < lat; j++) begin
            if (o_done && got_lat < 0) got_lat = j;
            i_wb_stall = j <= s;
            i_wb_ack = 0; i_wb_err = 0; i_wb_data = $urandom;
            if (!noack && j == s + 1 + d) begin
                if (berr) i_wb_err = 1;
                else begin
                    i_wb_ack = 1;
                    i_wb_data = mem[o_wb_addr];
                    for (int b = 0; b < 4; b++)
                        if (o_wb_we && o_wb_sel[b]) mem[o_wb_addr][8*b +: 8] = o_wb_data[8*b +: 8];
                end
            end
            if (j <= s + 1) begin
                check("wb_stb", o_wb_stb, 1);
                check("wb_addr", o_wb_addr, wa);
                check("wb_sel", o_wb_sel, sel_e);
                check("wb_we", o_wb_we, we);
                if (we) check("wb_data", o_wb_data, dat_e);
                if (j == 1) begin
                    cap_sel = o_wb_sel; cap_addr = o_wb_addr; cap_data = o_wb_data; cap_we = o_wb_we;
                end
            end else check("wb_stb_low", o_wb_stb, 0);
            i_stb = 1'($urandom); i_we = 1'($urandom); i_size = 2'($urandom);
            i_addr = $urandom; i_wdata = $urandom;
            @(posedge clk); #1;
        end
        if (lat > 1 && o_done && got_lat < 0) got_lat = lat;
        i_stb = 0; i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
        got_err = o_err;
        got_rd = o_rdata;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        #2;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_we", o_wb_we, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_sel", o_wb_sel, 0);
        check("rst_addr", o_wb_addr, 0);
        check("rst_data", o_wb_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        chk_en = 1;
        @(posedge clk); #1;

        xact(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 1, 0, 0);
        check("sw_addr", cap_addr, 4);
        check("sw_sel", cap_sel, 4'b1111);
        check("sw_we", cap_we, 1);
        check("sw_data", cap_data, 32'hDEADBEEF);
        check("sw_lat", got_lat, 3);
        check("sw_err", got_err, 0);
        xact(0, 2'd2, 0, 32'h10, 32'h0, 0, 1, 0, 0);
        check("lw_rdata", got_rd, 32'hDEADBEEF);

        mem[4] = 32'h80FF7F01;
        xact(0, 2'd0, 0, 32'h13, 32'h0, 0, 1, 0, 0);
        check("lb_rdata", got_rd, 32'hFFFFFF80);
        check("lb_sel", cap_sel, 4'b1000);
        xact(0, 2'd0, 1, 32'h13, 32'h0, 0, 1, 0, 0);
        check("lbu_rdata", got_rd, 32'h00000080);
        check("lbu_sel", cap_sel, 4'b1000);

        xact(1, 2'd1, 0, 32'h6, 32'h0000ABCD, 0, 1, 0, 0);
        check("sh_sel", cap_sel, 4'b1100);
        check("sh_data", cap_data, 32'hABCDABCD);
        xact(0, 2'd1, 0, 32'h6, 32'h0, 0, 1, 0, 0);
        check("lh_rdata", got_rd, 32'hFFFFABCD);

        xact(0, 2'd2, 0, 32'h2, 32'h0, 0, 1, 0, 0);
        check("mis_w_lat", got_lat, 1);
        check("mis_w_err", got_err, 1);
        xact(1, 2'd1, 0, 32'h1, 32'h1234, 0, 1, 0, 0);
        check("mis_h_lat", got_lat, 1);
        check("mis_h_err", got_err, 1);
        xact(0, 2'd3, 0, 32'h0, 32'h0, 0, 1, 0, 0);
        check("ill_lat", got_lat, 1);
        check("ill_err", got_err, 1);

        xact(1, 2'd2, 0, 32'h20, 32'h01234567, 3, 1, 0, 0);
        check("stall_lat", got_lat, 6);
        check("stall_err", got_err, 0);
        xact(0, 2'd2, 0, 32'h20, 32'h0, 0, 1, 1, 0);
        check("berr_lat", got_lat, 3);
        check("berr_err", got_err, 1);
        check("berr_cyc", o_wb_cyc, 0);
        xact(0, 2'd2, 0, 32'h24, 32'h0, 0, 0, 0, 1);
        check("tmo_lat", got_lat, 6);
        check("tmo_err", got_err, 1);
        check("tmo_cyc", o_wb_cyc, 0);

        for (int n = 0; n < 300; n++) begin
            xact(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 255), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 15) == 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        chk_en = 0;
        i_stb = 1; i_we = 0; i_size = 2'd2; i_addr = 32'h30;
        @(posedge clk); #1;
        i_stb = 0;
        @(posedge clk); #1;
        check("pre_rst_cyc", o_wb_cyc, 1);
        check("pre_rst_stb", o_wb_stb, 0);
        rst = 1;
        #1;
        check("arst_cyc", o_wb_cyc, 0);
        check("arst_stb", o_wb_stb, 0);
        check("arst_busy", o_busy, 0);
        @(posedge clk); #1;
        rst = 0;
        i_wb_ack = 1; i_wb_data = 32'h5A5A5A5A;
        @(posedge clk); #1;
        i_wb_ack = 0;
        for (int j = 0; j < 4; j++) begin
            check("late_done", o_done, 0);
            check("late_cyc", o_wb_cyc, 0);
            check("late_rdata", o_rdata, 0);
            @(posedge clk); #1;
        end
        acc_at = -10; done_at = -10; bus_x = 0; rd_model = '0; rd_known = 1;
        chk_en = 1;
        xact(0, 2'd2, 0, 32'h10, 32'h0, 0, 1, 0, 0);
        check("recover_rdata", got_rd, mem[4]);
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
